chunked_serial_adder: RTL and testbench

Multi-cycle, parametrised ripple-carry adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, carrying between chunks through a registered carry. It is the successor to the team's single-bit full-adder cell. It sits behind valid/ready handshakes so that datapath blocks can trade latency for area on wide adds.

---
 rtl/chunked_serial_adder.sv | 117 +++++++++++
 tb/tb_chunked_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle ripple-carry adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// with a registered inter-chunk carry behind valid/ready handshakes.
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   RUN   | adding chunk k each cycle
//   DONE  | result presented, waiting for out_ready
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, ans_q;
  logic [WIDTH-1:0] res_d;
  logic [CHUNK:0]   csum_d;
  logic [KW-1:0]    k_q;
  int               base_d;
  logic             carry_q, msb_a_q, msb_b_q;
  logic             cout_q, ovf_q, in_ready_q, out_valid_q;

  always_comb begin
    base_d = int'(k_q) * CHUNK;
    csum_d = {1'b0, a_q[base_d +: CHUNK]} + {1'b0, b_q[base_d +: CHUNK]}
           + {{CHUNK{1'b0}}, carry_q};
    res_d  = res_q;
    res_d[base_d +: CHUNK] = csum_d[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ans_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      msb_a_q     <= 1'b0;
      msb_b_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // subtraction is a + ~b + 1, so the carry seed replaces carry_in
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub | carry_in;
            msb_a_q    <= a[WIDTH-1];
            msb_b_q    <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            k_q        <= '0;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= csum_d[CHUNK];
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            k_q         <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            ans_q       <= res_d;
            cout_q      <= csum_d[CHUNK];
            ovf_q       <= (msb_a_q == msb_b_q) && (res_d[WIDTH-1] != msb_a_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ans       = ans_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: three instances (CHUNK 4, 16, 1) share operands;
// directed vectors push hand-computed results, per-instance monitors pop on each result handshake.
module tb_chunked_serial_adder;
  localparam int W = 16;
  localparam int NS [3] = '{4, 1, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, out_ready, carry_in, sub;
  logic [W-1:0] a, b;
  logic         iv [3];
  logic         in_ready_w [3], out_valid_w [3], cout_w [3], ovf_w [3];
  logic [W-1:0] ans_w [3];

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(in_ready_w[0]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .ans(ans_w[0]), .carry_out(cout_w[0]), .overflow(ovf_w[0]));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(in_ready_w[1]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .ans(ans_w[1]), .carry_out(cout_w[1]), .overflow(ovf_w[1]));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(in_ready_w[2]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .ans(ans_w[2]), .carry_out(cout_w[2]), .overflow(ovf_w[2]));

  typedef struct packed {
    logic [W-1:0] ans;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] va, vb;
    logic         cin, s;
    logic [W-1:0] ea;
    logic         ec, ev;
  } vec_t;

  exp_t sb [3][$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    int   ncnt   = 0;
    int   acc_n  = 0;
    logic prev_v = 1'b0;
    exp_t e;
    always @(negedge clk) begin
      ncnt++;
      if (!rst && iv[gi] && in_ready_w[gi]) acc_n = ncnt;
      chk($sformatf("rv_exclusive[%0d]", gi), {31'b0, in_ready_w[gi] & out_valid_w[gi]}, 0);
      if (out_valid_w[gi] && !prev_v)
        chk($sformatf("latency[%0d]", gi), ncnt - acc_n - 1, NS[gi]);
      if (!rst && out_valid_w[gi] && out_ready) begin
        if (sb[gi].size() == 0) begin
          chk($sformatf("unexpected_result[%0d]", gi), 1, 0);
        end else begin
          e = sb[gi].pop_front();
          chk($sformatf("ans[%0d]", gi), {16'b0, ans_w[gi]}, {16'b0, e.ans});
          chk($sformatf("carry_out[%0d]", gi), {31'b0, cout_w[gi]}, {31'b0, e.c});
          chk($sformatf("overflow[%0d]", gi), {31'b0, ovf_w[gi]}, {31'b0, e.v});
        end
      end
      prev_v = out_valid_w[gi];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] mask, input vec_t v, input bit push);
    int t = 0;
    while (!((!mask[0] || in_ready_w[0]) && (!mask[1] || in_ready_w[1]) &&
             (!mask[2] || in_ready_w[2])) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("issue_timeout", 1, 0);
    tick();
    a = v.va; b = v.vb; carry_in = v.cin; sub = v.s;
    for (int i = 0; i < 3; i++) begin
      iv[i] = mask[i];
      if (push && mask[i]) sb[i].push_back('{ans: v.ea, c: v.ec, v: v.ev});
    end
    tick();
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_in_ready[%0d]", tag, i), {31'b0, in_ready_w[i]}, 1);
      chk($sformatf("%s_out_valid[%0d]", tag, i), {31'b0, out_valid_w[i]}, 0);
      chk($sformatf("%s_ans[%0d]", tag, i), {16'b0, ans_w[i]}, 0);
      chk($sformatf("%s_carry[%0d]", tag, i), {31'b0, cout_w[i]}, 0);
      chk($sformatf("%s_ovf[%0d]", tag, i), {31'b0, ovf_w[i]}, 0);
    end
  endtask

  vec_t vecs [8];
  int   acc [2];
  int   nacc;
  int   t;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0};

    rst = 1'b1; out_ready = 1'b1; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    for (int i = 0; i < 8; i++) begin
      issue(3'b111, vecs[i], 1'b1);
      wait_idle();
    end

    // backpressure: result must hold while inputs churn
    out_ready = 1'b0;
    issue(3'b001, '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0}, 1'b1);
    t = 0;
    while (!out_valid_w[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("bp_timeout", 1, 0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid", {31'b0, out_valid_w[0]}, 1);
      chk("bp_ans", {16'b0, ans_w[0]}, 32'h3333);
      chk("bp_carry", {31'b0, cout_w[0]}, 0);
      chk("bp_ovf", {31'b0, ovf_w[0]}, 0);
      chk("bp_in_ready", {31'b0, in_ready_w[0]}, 0);
      tick();
      iv[0] = ~iv[0];
      a = 16'(k * 16'h1357 + 16'h00FF);
      b = 16'(k * 16'h2468 + 16'h0F00);
      sub = k[0];
      @(negedge clk);
    end
    tick();
    iv[0] = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, in_ready_w[0]}, 1);
    wait_idle();

    // back-to-back accepts with in_valid held high
    tick();
    a = 16'h0001; b = 16'h0002; carry_in = 1'b0; sub = 1'b0;
    iv[0] = 1'b1;
    nacc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready_w[0]) begin
        sb[0].push_back('{ans: 16'h0003, c: 1'b0, v: 1'b0});
        acc[nacc] = c;
        nacc++;
      end
      if (nacc == 2) break;
    end
    tick();
    iv[0] = 1'b0;
    chk("b2b_accepts", nacc, 2);
    if (nacc == 2) chk("b2b_spacing", acc[1] - acc[0], 6);
    wait_idle();

    // reset at the edge processing chunk 2 (third RUN edge)
    issue(3'b101, '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0}, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midrun_reset");
    issue(3'b111, vecs[7], 1'b1);
    wait_idle();

    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("sb_empty[%0d]", i), sb[i].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
